// File: rtl/d3_useq_pkg.sv
// Shared types and microword field layout for the D3-28 microprogram sequencer.
package d3_useq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_HALT
  } state_e;

  // Bit positions within En[44:1]
  localparam int F_TGT_HI = 44;
  localparam int F_TGT_LO = 36;
  localparam int F_SEL_HI = 35;
  localparam int F_SEL_LO = 33;
  localparam int F_INV    = 32;
  localparam int F_HALT   = 31;

  localparam logic [2:0] SEL_NEVER  = 3'd0;
  localparam logic [2:0] SEL_ALWAYS = 3'd1;

  localparam int CNT_W = 8;

endpackage

// File: rtl/ucode_cond_mux.sv
// Branch condition selector: never / always / one datapath flag, optionally inverted.
module ucode_cond_mux
  import d3_useq_pkg::*;
(
  input  logic [2:0] sel,
  input  logic       inv,
  input  logic [5:0] cond_in,
  output logic       take_branch
);

  logic [2:0] idx;
  logic       raw;

  always_comb begin
    idx = sel - 3'd2;
    raw = 1'b0;
    if (sel == SEL_ALWAYS) begin
      raw = 1'b1;
    end else if (sel != SEL_NEVER) begin
      raw = cond_in[idx];
    end
    // Inversion never turns "never branch" into a branch
    take_branch = (sel == SEL_NEVER) ? 1'b0 : (raw ^ inv);
  end

endmodule

// File: rtl/ucode_seq.sv
// Microprogram sequencer: ROM fetch handshake, microword register, t1n..t5n strobes
// and next-microaddress selection, under run/step/halt panel control.
module ucode_seq
  import d3_useq_pkg::*;
#(
  parameter int          AW         = 9,
  parameter int unsigned RESET_ADDR = 0,
  parameter int          TIMEOUT    = 15
) (
  input  logic          main_clk,
  input  logic          res_n,
  input  logic          run,
  input  logic          step,
  input  logic [5:0]    cond_in,
  input  logic [43:0]   rom_data,
  input  logic          rom_ack,
  output logic          rom_req,
  output logic [AW-1:0] rom_addr,
  output logic [44:1]   En,
  output logic          t1n,
  output logic          t2n,
  output logic          t3n,
  output logic          t4n,
  output logic          t5n,
  output logic          busy,
  output logic          halted,
  output logic          fault
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [AW-1:0]    UPC_RST  = AW'(RESET_ADDR);

  state_e           state_q, state_d;
  logic [AW-1:0]    upc_q, upc_d;
  logic [44:1]      en_q, en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             fault_q, fault_d;
  logic             take_branch;

  ucode_cond_mux u_cond (
    .sel         (en_q[F_SEL_HI:F_SEL_LO]),
    .inv         (en_q[F_INV]),
    .cond_in     (cond_in),
    .take_branch (take_branch)
  );

  always_ff @(posedge main_clk) begin
    if (!res_n) begin
      state_q <= S_IDLE;
      upc_q   <= UPC_RST;
      en_q    <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    fault_d = fault_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (run) begin
          state_d = S_FETCH;
          step_d  = 1'b0;
        end else if (step) begin
          state_d = S_FETCH;
          step_d  = 1'b1;
        end
      end
      S_FETCH: begin
        // An ack on the same edge as the limit still wins
        if (rom_ack) begin
          en_d    = rom_data;
          cnt_d   = '0;
          state_d = S_T1;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          cnt_d   = '0;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: state_d = S_T4;
      S_T4: state_d = S_T5;
      S_T5: begin
        upc_d = take_branch ? en_q[F_TGT_LO +: AW] : upc_q + AW'(1);
        if (en_q[F_HALT]) begin
          state_d = S_HALT;
          step_d  = 1'b0;
        end else if (step_q) begin
          state_d = S_IDLE;
          step_d  = 1'b0;
        end else if (!run) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT: if (!run) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_req  = (state_q == S_FETCH);
  assign rom_addr = upc_q;
  assign En       = en_q;
  assign t1n      = (state_q != S_T1);
  assign t2n      = (state_q != S_T2);
  assign t3n      = (state_q != S_T3);
  assign t4n      = (state_q != S_T4);
  assign t5n      = (state_q != S_T5);
  assign busy     = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted   = (state_q == S_HALT);
  assign fault    = fault_q;

endmodule

// File: tb/tb_ucode_seq.sv
// Bench for ucode_seq: behavioural ROM, fetch-address scoreboard, branch vector table
// and hand-written sequences for step, timeout, halt and mid-cycle reset.
module tb_ucode_seq;

  localparam int AW = 9;

  logic          main_clk = 1'b0;
  logic          res_n = 1'b0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic [5:0]    cond_in = '0;
  logic [43:0]   rom_data;
  logic          rom_ack;
  logic          rom_req;
  logic [AW-1:0] rom_addr;
  logic [44:1]   En;
  logic          t1n, t2n, t3n, t4n, t5n;
  logic          busy, halted, fault;
  logic [4:0]    tn;

  logic [43:0]   rom [0:511];
  logic          ack_en = 1'b1;
  int            ack_lat = 0;
  int            wcnt = 0;

  int            checks = 0;
  int            failures = 0;
  logic [8:0]    exp_q[$];
  logic [8:0]    exp_a;

  typedef struct {
    logic [8:0] addr;
    logic [8:0] tgt;
    logic [2:0] sel;
    logic       inv;
    logic [5:0] cond;
    logic [8:0] nxt;
  } vec_t;
  vec_t vt[9];

  ucode_seq #(.AW(AW), .RESET_ADDR(0), .TIMEOUT(15)) dut (
    .main_clk (main_clk),
    .res_n    (res_n),
    .run      (run),
    .step     (step),
    .cond_in  (cond_in),
    .rom_data (rom_data),
    .rom_ack  (rom_ack),
    .rom_req  (rom_req),
    .rom_addr (rom_addr),
    .En       (En),
    .t1n      (t1n),
    .t2n      (t2n),
    .t3n      (t3n),
    .t4n      (t4n),
    .t5n      (t5n),
    .busy     (busy),
    .halted   (halted),
    .fault    (fault)
  );

  always #5 main_clk = ~main_clk;

  assign tn       = {t5n, t4n, t3n, t2n, t1n};
  assign rom_data = rom[rom_addr];
  assign rom_ack  = rom_req && ack_en && (wcnt >= ack_lat);

  always @(posedge main_clk) begin
    if (rom_req && !rom_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every completed fetch must match the next expected microaddress
  always @(negedge main_clk) begin
    if (res_n && rom_req && rom_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_fetch: got addr %0h expected no fetch", rom_addr);
      end else begin
        exp_a = exp_q.pop_front();
        chk("fetch_addr", 64'(rom_addr), 64'(exp_a));
      end
    end
  end

  function automatic logic [43:0] mk(input logic [8:0] tgt, input logic [2:0] sel,
                                     input logic inv, input logic hlt, input int dec);
    logic [43:0] w;
    w        = '0;
    w[43:35] = tgt;
    w[34:32] = sel;
    w[31]    = inv;
    w[30]    = hlt;
    w[27:0]  = 28'(dec);
    return w;
  endfunction

  task automatic do_reset();
    res_n = 1'b0; run = 1'b0; step = 1'b0; cond_in = '0;
    ack_en = 1'b1; ack_lat = 0;
    repeat (2) @(negedge main_clk);
    res_n = 1'b1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},    64'(rom_req), 64'(0));
    chk({tag, "_addr"},   64'(rom_addr), 64'(0));
    chk({tag, "_en"},     64'(En), 64'(0));
    chk({tag, "_tn"},     64'(tn), 64'(5'h1F));
    chk({tag, "_busy"},   64'(busy), 64'(0));
    chk({tag, "_halted"}, 64'(halted), 64'(0));
    chk({tag, "_fault"},  64'(fault), 64'(0));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge main_clk);
      n++;
    end
    chk({tag, "_idle_timeout"}, 64'(busy), 64'(0));
  endtask

  task automatic wait_low(input int k, input string tag);
    int n = 0;
    while (tn[k] !== 1'b0 && n < 50) begin
      @(negedge main_clk);
      n++;
    end
    chk({tag, "_strobe_wait"}, 64'(tn[k]), 64'(0));
  endtask

  task automatic do_step();
    step = 1'b1;
    @(negedge main_clk);
    step = 1'b0;
    wait_idle("step");
  endtask

  task automatic glitch_t2(input logic base, input logic [8:0] nxt);
    do_reset();
    rom[0]  = mk(9'h005, 3'd1, 1'b0, 1'b0, 11);
    rom[5]  = mk(9'h040, 3'd2, 1'b0, 1'b0, 12);
    cond_in = {5'b0, base};
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h005);
    exp_q.push_back(nxt);
    do_step();
    step = 1'b1;
    @(negedge main_clk);
    step = 1'b0;
    wait_low(1, "glitch");
    cond_in = {5'b0, ~base};
    @(negedge main_clk);
    cond_in = {5'b0, base};
    wait_idle("glitch");
    do_step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [4:0] e;

    for (int i = 0; i < 512; i++) rom[i] = mk(9'h000, 3'd0, 1'b0, 1'b0, i * 7 + 3);

    vt[0] = '{9'h005, 9'h040, 3'd2, 1'b0, 6'b000001, 9'h040};
    vt[1] = '{9'h005, 9'h040, 3'd2, 1'b0, 6'b000000, 9'h006};
    vt[2] = '{9'h1FF, 9'h012, 3'd0, 1'b0, 6'b111111, 9'h000};
    vt[3] = '{9'h007, 9'h123, 3'd1, 1'b0, 6'b000000, 9'h123};
    vt[4] = '{9'h007, 9'h123, 3'd1, 1'b1, 6'b000000, 9'h008};
    vt[5] = '{9'h009, 9'h055, 3'd0, 1'b1, 6'b111111, 9'h00A};
    vt[6] = '{9'h020, 9'h033, 3'd7, 1'b0, 6'b100000, 9'h033};
    vt[7] = '{9'h020, 9'h033, 3'd4, 1'b1, 6'b000100, 9'h021};
    vt[8] = '{9'h030, 9'h077, 3'd3, 1'b1, 6'b111101, 9'h077};

    // Reset values while held in reset
    res_n = 1'b0;
    repeat (3) @(negedge main_clk);
    chk_reset("rst");
    res_n = 1'b1;

    // Free-running sequential words 0..3 with exact strobe timing
    for (int k = 0; k < 4; k++) exp_q.push_back(9'(k));
    run = 1'b1;
    @(negedge main_clk);
    n = 0;
    while (!rom_req && n < 10) begin
      @(negedge main_clk);
      n++;
    end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 6; j++) begin
        if (j == 0) begin
          chk("seq_req", 64'(rom_req), 64'(1));
          chk("seq_addr", 64'(rom_addr), 64'(k));
          chk("seq_tn_fetch", 64'(tn), 64'(5'h1F));
        end else begin
          e = ~(5'(1) << (j - 1));
          chk("seq_tn", 64'(tn), 64'(e));
          if (j == 1) chk("seq_en", 64'(En), 64'(rom[k]));
        end
        if (k == 3 && j == 3) run = 1'b0;
        @(negedge main_clk);
      end
    end
    chk("seq_stop_busy", 64'(busy), 64'(0));
    chk("seq_stop_req", 64'(rom_req), 64'(0));

    // Branch decision table: jump to addr, execute the vector word, observe next fetch
    for (int v = 0; v < 9; v++) begin
      do_reset();
      rom[0] = mk(vt[v].addr, 3'd1, 1'b0, 1'b0, 5);
      rom[vt[v].addr] = mk(vt[v].tgt, vt[v].sel, vt[v].inv, 1'b0, v + 100);
      cond_in = vt[v].cond;
      exp_q.push_back(9'h000);
      exp_q.push_back(vt[v].addr);
      exp_q.push_back(vt[v].nxt);
      do_step();
      do_step();
      do_step();
      chk("vec_sb_drain", 64'(exp_q.size()), 64'(0));
    end

    // cond_in only matters at T5
    glitch_t2(1'b1, 9'h040);
    glitch_t2(1'b0, 9'h006);

    // Single step, with a second step during T3 dropped
    do_reset();
    rom[0] = mk(9'h000, 3'd0, 1'b0, 1'b0, 21);
    exp_q.push_back(9'h000);
    step = 1'b1;
    @(negedge main_clk);
    step = 1'b0;
    wait_low(2, "step2");
    step = 1'b1;
    @(negedge main_clk);
    step = 1'b0;
    wait_idle("step2");
    repeat (10) @(negedge main_clk);
    chk("step2_busy", 64'(busy), 64'(0));
    chk("step2_addr", 64'(rom_addr), 64'(1));

    // Ack on the last permitted FETCH clock still succeeds
    do_reset();
    ack_lat = 14;
    rom[0] = mk(9'h000, 3'd0, 1'b0, 1'b0, 22);
    exp_q.push_back(9'h000);
    step = 1'b1;
    @(negedge main_clk);
    step = 1'b0;
    n = 0;
    while (rom_req && n < 40) begin
      n++;
      @(negedge main_clk);
    end
    chk("late_ack_fetch_len", 64'(n), 64'(15));
    wait_idle("late_ack");
    chk("late_ack_fault", 64'(fault), 64'(0));
    chk("late_ack_addr", 64'(rom_addr), 64'(1));

    // ROM never acks: fault after 15 FETCH clocks, En kept
    do_reset();
    rom[0] = mk(9'h000, 3'd0, 1'b0, 1'b0, 23);
    exp_q.push_back(9'h000);
    do_step();
    ack_en = 1'b0;
    run = 1'b1;
    @(negedge main_clk);
    n = 0;
    while (rom_req && n < 40) begin
      n++;
      @(negedge main_clk);
    end
    chk("to_fetch_len", 64'(n), 64'(15));
    chk("to_fault", 64'(fault), 64'(1));
    chk("to_halted", 64'(halted), 64'(1));
    chk("to_en_kept", 64'(En), 64'(rom[0]));
    step = 1'b1;
    @(negedge main_clk);
    step = 1'b0;
    @(negedge main_clk);
    chk("to_step_ignored", 64'(halted), 64'(1));
    run = 1'b0;
    @(negedge main_clk);
    chk("to_idle_halted", 64'(halted), 64'(0));
    chk("to_idle_busy", 64'(busy), 64'(0));
    chk("to_fault_sticky", 64'(fault), 64'(1));

    // Halt bit, then reset during T3 of the next run
    do_reset();
    rom[0] = mk(9'h000, 3'd0, 1'b0, 1'b1, 24);
    rom[1] = mk(9'h000, 3'd0, 1'b0, 1'b0, 25);
    exp_q.push_back(9'h000);
    run = 1'b1;
    n = 0;
    while (!halted && n < 20) begin
      @(negedge main_clk);
      n++;
    end
    chk("halt_halted", 64'(halted), 64'(1));
    chk("halt_busy", 64'(busy), 64'(0));
    chk("halt_addr", 64'(rom_addr), 64'(1));
    run = 1'b0;
    @(negedge main_clk);
    chk("halt_release", 64'(halted), 64'(0));
    exp_q.push_back(9'h001);
    run = 1'b1;
    wait_low(2, "midrst");
    res_n = 1'b0;
    @(negedge main_clk);
    chk_reset("midrst");
    res_n = 1'b1;
    run = 1'b0;

    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ucode_seq.md
# ucode_seq

Microprogram sequencer for the D3-28 control unit. Fetches 44-bit microwords from an external microcode ROM over a req/ack handshake, holds the current word on the `En[44:1]` bus that feeds the 1w/3w/4w/8w/10w decoders, and generates the five active-low time strobes t1n..t5n per microcycle. It also computes the next microaddress: sequential or conditional branch. Run/step/halt control comes from the operator panel.

## Interface
Parameters:
- `AW`, 9: microaddress width.
- `RESET_ADDR`, 0: microaddress loaded on reset.
- `TIMEOUT`, 15: maximum clocks waiting for `rom_ack` before a fault; range 1..255.

Ports:
- `main_clk`  in  1  system clock; all state changes on its rising edge.
- `res_n`  in  1  reset, synchronous, active-low.
- `run`  in  1  level; 1 = free-running microcycles.
- `step`  in  1  one-clock pulse; executes exactly one microcycle while idle.
- `cond_in`  in  6  datapath condition flags (carry, zero, sign, tape-ready, etc.).
- `rom_data`  in  44  microword, bit i of the port maps to `En[i+1]`.
- `rom_ack`  in  1  ROM data valid; honored only while `rom_req` is 1.
- `rom_req`  out  1  fetch request.
- `rom_addr`  out  AW  equals `upc`.
- `En`  out  44  microword register `[44:1]`.
- `t1n`..`t5n`  out  1 each  time strobes, active-low.
- `busy`  out  1  1 in FETCH or T1..T5.
- `halted`  out  1  1 in HALT.
- `fault`  out  1  sticky ROM timeout flag.

## Operation
Microword sequencing fields (bits 1..28 belong to the decoders):
- `En[44:36]` branch target. Only the low AW bits are used; upper bits are ignored.
- `En[35:33]` condition select:
  - 0 = never branch.
  - 1 = always branch.
  - 2..7 = `cond_in[sel-2]`.
- `En[32]` invert the selected condition. It does not apply to select 0.
- `En[31]` halt after this microcycle.
- `En[30:29]` reserved, ignored.

States: IDLE, FETCH, T1, T2, T3, T4, T5, HALT.
- **IDLE:**
  - `run`=1 → FETCH.
  - Else `step`=1 → FETCH with the single-step flag set.
  - `run` has priority when both are high.
- **FETCH:**
  - `rom_req`=1 and the wait counter increments.
  - On `rom_ack`=1: load `En` from `rom_data`, `rom_req`←0, go to T1.
  - If the counter reaches TIMEOUT without ack: `fault`←1, go to HALT. `En` is unchanged.
- **T1→T2→T3→T4→T5:** one clock each. `tkn`=0 only in state Tk.
- **At exit from T5:**
  - `upc` ← target if the branch is taken, else `upc+1` modulo 2^AW. `upc` wraps from all-ones to 0.
  - Next state, first matching rule wins:
    1. `En[31]`=1 → HALT.
    2. Single-step flag set → IDLE, and the flag is cleared.
    3. `run`=0 → IDLE.
    4. Otherwise → FETCH.
- **HALT:**
  - Remains while `run`=1.
  - `run`=0 → IDLE.
  - `step` is ignored.
  - `fault` is cleared only by reset.
- `En` holds its value across IDLE and HALT, so the decoders keep the last word.

## Timing
- Reset values:
  - state = IDLE.
  - `upc` = RESET_ADDR.
  - `En` = 0 (a NOP for all decoders).
  - `rom_req`=0, t1n..t5n=1.
  - `busy`=0, `halted`=0, `fault`=0.
  - wait counter 0, step flag 0.
- Reset mid-operation: any state returns to the reset values on the next edge. A pending `rom_ack` is ignored.
- All outputs are registered or decoded from registered state, so they are glitch-free.
- `rom_addr` is stable for the whole of FETCH.
- Microcycle length with ack in the first FETCH clock: 1 (FETCH) + 5 (T1..T5) = 6 clocks. Each extra ack wait adds 1 clock.
- `cond_in` is sampled only on the T5 edge. Changes during T1..T4 have no effect.
- `rom_ack` outside FETCH is ignored. An ack arriving on the same edge the timeout is reached counts as success.
- `step` pulses while busy are dropped, not queued.
- `run` falling during T1..T4 does not abort the cycle; it is acted on at the T5 exit.

## Structure
- Package `d3_useq_pkg` holds:
  - the state enum;
  - the field positions (`F_TGT_HI/LO`, `F_SEL_HI/LO`, `F_INV`, `F_HALT`);
  - the condition-select codes `SEL_NEVER`=0 and `SEL_ALWAYS`=1.
- Sub-module `ucode_cond_mux` (combinational) takes sel, inv and `cond_in` and outputs `take_branch`.
- Strobe generation, the wait counter and the next-address logic live in the top module.

## Test plan
- Reset, then `run`=1, ROM acks immediately, words are sequential with sel=0 → fetched addresses 0,1,2,3. Each cycle is 6 clocks and t1n..t5n are each low for exactly one clock, in order.
- Word at addr 5: sel=2, inv=0, target=0x40.
  - `cond_in[0]`=1 at T5 → next `rom_addr`=0x40.
  - Repeat with `cond_in[0]`=0 → next address 6.
  - Toggle `cond_in[0]` during T2 only → no effect.
- `upc`=0x1FF with sequential word → next address 0x000 (wrap).
- ROM never acks with TIMEOUT=15 → after 15 FETCH clocks `fault`=1, `halted`=1, `En` unchanged. `run`=0 → IDLE with `fault` still 1.
- `run`=0, one `step` pulse → exactly one microcycle, then IDLE. A second `step` during T3 is ignored.
- Word with `En[31]`=1 → HALT after T5 with `halted`=1. Assert `res_n`=0 during T3 of the next run → all outputs return to reset values on the next edge.
